// File: rtl/decode_stage_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU codes, operand selects and the
// registered control bundle handed to execute.
package decode_stage_pkg;

   localparam int unsigned ALU_OP_WIDTH = 5;

   localparam logic [6:0] OPCODE_LOAD           = 7'b0000011;
   localparam logic [6:0] OPCODE_MISC_MEM       = 7'b0001111;
   localparam logic [6:0] OPCODE_OPERATION_IMM  = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC          = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE          = 7'b0100011;
   localparam logic [6:0] OPCODE_OPERATION_REG  = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI            = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH         = 7'b1100011;
   localparam logic [6:0] OPCODE_JUMP_LINK_REG  = 7'b1100111;
   localparam logic [6:0] OPCODE_JUMP_LINK_IMM  = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM         = 7'b1110011;

   localparam logic [6:0] FUNC7_BASE = 7'b0000000;
   localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNC7_MUL  = 7'b0000001;

   localparam logic [2:0]  FUNC3_SYSTEM_PRIV = 3'b000;
   localparam logic [2:0]  FUNC3_SYSTEM_RSVD = 3'b100;
   localparam logic [11:0] FUNC12_ECALL      = 12'h000;
   localparam logic [11:0] FUNC12_EBREAK     = 12'h001;
   localparam logic [11:0] FUNC12_MRET       = 12'h302;

   localparam logic [2:0] CSR_OP_NONE = 3'b000;
   localparam logic [2:0] CSR_OP_RW   = 3'b001;
   localparam logic [2:0] CSR_OP_RS   = 3'b010;
   localparam logic [2:0] CSR_OP_RC   = 3'b011;
   localparam logic [2:0] CSR_OP_RWI  = 3'b101;
   localparam logic [2:0] CSR_OP_RSI  = 3'b110;
   localparam logic [2:0] CSR_OP_RCI  = 3'b111;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 5'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 5'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 5'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 5'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 5'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ     = 5'd10;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_NE     = 5'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LT     = 5'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_GE     = 5'd13;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU    = 5'd14;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU    = 5'd15;
   // M-extension codes are contiguous in func3 order so they can be indexed by func3.
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd16;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd17;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd18;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd19;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd20;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd21;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd22;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd23;

   localparam logic [1:0] TYPE_A_RD1  = 2'd0;
   localparam logic [1:0] TYPE_A_PC   = 2'd1;
   localparam logic [1:0] TYPE_A_ZERO = 2'd2;

   localparam logic [2:0] TYPE_B_RD2     = 3'd0;
   localparam logic [2:0] TYPE_B_IMM_I   = 3'd1;
   localparam logic [2:0] TYPE_B_IMM_S   = 3'd2;
   localparam logic [2:0] TYPE_B_IMM_U   = 3'd3;
   localparam logic [2:0] TYPE_B_CONST_4 = 3'd4;

   localparam logic [2:0] DATA_SIZE_BYTE = 3'b000;
   localparam logic [2:0] DATA_SIZE_HALF = 3'b001;
   localparam logic [2:0] DATA_SIZE_WORD = 3'b010;

   localparam logic [1:0] WB_FROM_RESULT = 2'd0;
   localparam logic [1:0] WB_FROM_MEM    = 2'd1;
   localparam logic [1:0] WB_FROM_CSR    = 2'd2;

   typedef enum logic [2:0] {FmtNone, FmtI, FmtS, FmtB, FmtU, FmtJ} imm_fmt_e;

   typedef struct packed {
      logic [ALU_OP_WIDTH-1:0] alu_operation;
      logic [1:0]              operand_a_type;
      logic [2:0]              operand_b_type;
      logic                    memory_require;
      logic                    memory_write_enable;
      logic [2:0]              memory_size;
      logic                    reg_file_write_enable;
      logic [1:0]              wb_sel;
      logic                    branch_flag;
      logic                    jal_flag;
      logic                    jalr_flag;
      logic                    stop_signal;
      logic                    mret_flag;
      logic                    illegal_flag;
      logic [2:0]              csr_op;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{ALU_ADD, TYPE_A_RD1, TYPE_B_RD2, 1'b0, 1'b0, DATA_SIZE_BYTE,
                                    1'b0, WB_FROM_RESULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    CSR_OP_NONE};

   function automatic logic [ALU_OP_WIDTH-1:0] alu_base_op(input logic [2:0] func3);
      case (func3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [ALU_OP_WIDTH-1:0] alu_mul_op(input logic [2:0] func3);
      return ALU_MUL + {2'b00, func3};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus the decoded control bundle of the decode stage.
interface decode_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   import decode_stage_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [31:0]             in_instr;
   logic [XLEN-1:0]         in_pc;
   logic                    flush;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [XLEN-1:0]         imm;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic [4:0]              rd;
   logic [ALU_OP_WIDTH-1:0] alu_operation;
   logic [1:0]              operand_A_type;
   logic [2:0]              operand_B_type;
   logic                    memory_require;
   logic                    memory_write_enable;
   logic [2:0]              memory_size;
   logic                    reg_file_write_enable;
   logic [1:0]              wb_sel;
   logic                    branch_flag;
   logic                    jal_flag;
   logic                    jalr_flag;
   logic                    stop_signal;
   logic                    mret_flag;
   logic                    illegal_flag;
   logic [2:0]              csr_op;
   logic [CNT_W-1:0]        illegal_count;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, imm, rs1, rs2, rd, alu_operation, operand_A_type,
             operand_B_type, memory_require, memory_write_enable, memory_size,
             reg_file_write_enable, wb_sel, branch_flag, jal_flag, jalr_flag, stop_signal,
             mret_flag, illegal_flag, csr_op, illegal_count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, imm, rs1, rs2, rd, alu_operation, operand_A_type,
             operand_B_type, memory_require, memory_write_enable, memory_size,
             reg_file_write_enable, wb_sel, branch_flag, jal_flag, jalr_flag, stop_signal,
             mret_flag, illegal_flag, csr_op, illegal_count
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; format is chosen from the opcode field.
module decode_stage_imm_gen
   import decode_stage_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   imm_fmt_e fmt;

   always_comb begin
      case (instr_i[6:0])
         OPCODE_OPERATION_IMM, OPCODE_LOAD,
         OPCODE_JUMP_LINK_REG, OPCODE_SYSTEM: fmt = FmtI;
         OPCODE_STORE:                        fmt = FmtS;
         OPCODE_BRANCH:                       fmt = FmtB;
         OPCODE_LUI, OPCODE_AUIPC:            fmt = FmtU;
         OPCODE_JUMP_LINK_IMM:                fmt = FmtJ;
         default:                             fmt = FmtNone;
      endcase
   end

   always_comb begin
      case (fmt)
         FmtI:    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         FmtS:    imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         FmtB:    imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
         FmtU:    imm_o = {instr_i[31:12], 12'h000};
         FmtJ:    imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
         default: imm_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready in and out, flush, optional M/Zicsr decode and
// a saturating count of accepted illegal instructions.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter bit          EN_MUL = 1'b0,
   parameter bit          EN_CSR = 1'b0,
   parameter int unsigned CNT_W  = 16
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);

   logic [31:0]      instr;
   logic [6:0]       opcode;
   logic [2:0]       func3;
   logic [6:0]       func7;
   logic [31:0]      imm_dec;
   ctrl_t            ctrl_dec;
   logic             illegal;
   logic             accept;

   ctrl_t            ctrl_q, ctrl_d;
   logic             valid_q, valid_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign func3  = instr[14:12];
   assign func7  = instr[31:25];

   decode_stage_imm_gen imm_gen (
      .instr_i (instr),
      .imm_o   (imm_dec)
   );

   always_comb begin
      ctrl_dec = CTRL_RESET;
      illegal  = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPCODE_LUI: begin
               ctrl_dec.operand_a_type        = TYPE_A_ZERO;
               ctrl_dec.operand_b_type        = TYPE_B_IMM_U;
               ctrl_dec.reg_file_write_enable = 1'b1;
            end
            OPCODE_AUIPC: begin
               ctrl_dec.operand_a_type        = TYPE_A_PC;
               ctrl_dec.operand_b_type        = TYPE_B_IMM_U;
               ctrl_dec.reg_file_write_enable = 1'b1;
            end
            OPCODE_JUMP_LINK_IMM, OPCODE_JUMP_LINK_REG: begin
               ctrl_dec.operand_a_type        = TYPE_A_PC;
               ctrl_dec.operand_b_type        = TYPE_B_CONST_4;
               ctrl_dec.reg_file_write_enable = 1'b1;
               ctrl_dec.jal_flag              = (opcode == OPCODE_JUMP_LINK_IMM);
               ctrl_dec.jalr_flag             = (opcode == OPCODE_JUMP_LINK_REG);
               if (opcode == OPCODE_JUMP_LINK_REG && func3 != 3'b000) illegal = 1'b1;
            end
            OPCODE_BRANCH: begin
               ctrl_dec.branch_flag = 1'b1;
               case (func3)
                  3'b000:  ctrl_dec.alu_operation = ALU_EQ;
                  3'b001:  ctrl_dec.alu_operation = ALU_NE;
                  3'b100:  ctrl_dec.alu_operation = ALU_LT;
                  3'b101:  ctrl_dec.alu_operation = ALU_GE;
                  3'b110:  ctrl_dec.alu_operation = ALU_LTU;
                  3'b111:  ctrl_dec.alu_operation = ALU_GEU;
                  default: illegal = 1'b1;
               endcase
            end
            OPCODE_LOAD: begin
               ctrl_dec.memory_require        = 1'b1;
               ctrl_dec.memory_size           = func3;
               ctrl_dec.operand_b_type        = TYPE_B_IMM_I;
               ctrl_dec.reg_file_write_enable = 1'b1;
               ctrl_dec.wb_sel                = WB_FROM_MEM;
               if (func3 == 3'b011 || func3[2:1] == 2'b11) illegal = 1'b1;
            end
            OPCODE_STORE: begin
               ctrl_dec.memory_require      = 1'b1;
               ctrl_dec.memory_write_enable = 1'b1;
               ctrl_dec.memory_size         = func3;
               ctrl_dec.operand_b_type      = TYPE_B_IMM_S;
               if (func3 > DATA_SIZE_WORD) illegal = 1'b1;
            end
            OPCODE_OPERATION_IMM: begin
               ctrl_dec.operand_b_type        = TYPE_B_IMM_I;
               ctrl_dec.reg_file_write_enable = 1'b1;
               ctrl_dec.alu_operation         = alu_base_op(func3);
               // Shift-immediates reuse func7 as an opcode extension.
               if (func3 == 3'b001 && func7 != FUNC7_BASE) illegal = 1'b1;
               if (func3 == 3'b101) begin
                  if (func7 == FUNC7_ALT) ctrl_dec.alu_operation = ALU_SRA;
                  else if (func7 != FUNC7_BASE) illegal = 1'b1;
               end
            end
            OPCODE_OPERATION_REG: begin
               ctrl_dec.reg_file_write_enable = 1'b1;
               if (func7 == FUNC7_BASE) ctrl_dec.alu_operation = alu_base_op(func3);
               else if (func7 == FUNC7_ALT && func3 == 3'b000) ctrl_dec.alu_operation = ALU_SUB;
               else if (func7 == FUNC7_ALT && func3 == 3'b101) ctrl_dec.alu_operation = ALU_SRA;
               else if (func7 == FUNC7_MUL && EN_MUL) ctrl_dec.alu_operation = alu_mul_op(func3);
               else illegal = 1'b1;
            end
            OPCODE_MISC_MEM: begin
               if (func3[2:1] != 2'b00) illegal = 1'b1;
            end
            OPCODE_SYSTEM: begin
               if (func3 == FUNC3_SYSTEM_PRIV) begin
                  if (instr[19:7] != 13'h0) illegal = 1'b1;
                  case (instr[31:20])
                     FUNC12_ECALL, FUNC12_EBREAK: ctrl_dec.stop_signal = 1'b1;
                     FUNC12_MRET: begin
                        if (EN_CSR) ctrl_dec.mret_flag = 1'b1;
                        else illegal = 1'b1;
                     end
                     default: illegal = 1'b1;
                  endcase
               end else if (func3 == FUNC3_SYSTEM_RSVD || !EN_CSR) begin
                  illegal = 1'b1;
               end else begin
                  ctrl_dec.reg_file_write_enable = 1'b1;
                  ctrl_dec.wb_sel                = WB_FROM_CSR;
                  ctrl_dec.csr_op                = func3;
               end
            end
            default: illegal = 1'b1;
         endcase
      end
      if (illegal) begin
         ctrl_dec              = CTRL_RESET;
         ctrl_dec.illegal_flag = 1'b1;
      end
   end

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      ctrl_d = ctrl_q;
      pc_d   = pc_q;
      imm_d  = imm_q;
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      if (accept) begin
         ctrl_d = ctrl_dec;
         pc_d   = bus.in_pc;
         imm_d  = imm_dec;
         rs1_d  = instr[19:15];
         rs2_d  = instr[24:20];
         rd_d   = instr[11:7];
         if (ctrl_dec.illegal_flag && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
      if (bus.flush)          valid_d = 1'b0;
      else if (accept)        valid_d = 1'b1;
      else if (bus.out_ready) valid_d = 1'b0;
      else                    valid_d = valid_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_RESET;
         pc_q    <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.out_valid             = valid_q;
   assign bus.out_pc                = pc_q;
   assign bus.imm                   = imm_q;
   assign bus.rs1                   = rs1_q;
   assign bus.rs2                   = rs2_q;
   assign bus.rd                    = rd_q;
   assign bus.alu_operation         = ctrl_q.alu_operation;
   assign bus.operand_A_type        = ctrl_q.operand_a_type;
   assign bus.operand_B_type        = ctrl_q.operand_b_type;
   assign bus.memory_require        = ctrl_q.memory_require;
   assign bus.memory_write_enable   = ctrl_q.memory_write_enable;
   assign bus.memory_size           = ctrl_q.memory_size;
   assign bus.reg_file_write_enable = ctrl_q.reg_file_write_enable;
   assign bus.wb_sel                = ctrl_q.wb_sel;
   assign bus.branch_flag           = ctrl_q.branch_flag;
   assign bus.jal_flag              = ctrl_q.jal_flag;
   assign bus.jalr_flag             = ctrl_q.jalr_flag;
   assign bus.stop_signal           = ctrl_q.stop_signal;
   assign bus.mret_flag             = ctrl_q.mret_flag;
   assign bus.illegal_flag          = ctrl_q.illegal_flag;
   assign bus.csr_op                = ctrl_q.csr_op;
   assign bus.illegal_count         = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: dut_a has M and Zicsr decode enabled, dut_b has both disabled and a 2-bit
// illegal counter; both see identical stimulus.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .CNT_W(16)) ifa ();
   decode_stage_if #(.XLEN(32), .CNT_W(2))  ifb ();

   decode_stage #(.XLEN(32), .EN_MUL(1'b1), .EN_CSR(1'b1), .CNT_W(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   decode_stage #(.XLEN(32), .EN_MUL(1'b0), .EN_CSR(1'b0), .CNT_W(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      ifa.in_valid = v; ifa.in_instr = instr; ifa.in_pc = pc;
      ifb.in_valid = v; ifb.in_instr = instr; ifb.in_pc = pc;
   endtask

   task automatic set_ready(input logic r);
      ifa.out_ready = r; ifb.out_ready = r;
   endtask

   task automatic set_flush(input logic f);
      ifa.flush = f; ifb.flush = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 32'h0, 32'h0); set_ready(1'b1); set_flush(1'b0);
      reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
      checks++; if (ifa.out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid got %0h want 0", ifa.out_valid); end
      checks++; if (ifa.in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %0h want 1", ifa.in_ready); end
      checks++; if (ifa.imm !== 32'h0 || ifa.out_pc !== 32'h0 || ifa.rd !== 5'h0) begin errors++;
         $display("FAIL reset_data got imm %h pc %h rd %h want 0", ifa.imm, ifa.out_pc, ifa.rd); end
      checks++; if (ifa.alu_operation !== ALU_ADD || ifa.operand_A_type !== TYPE_A_RD1 ||
                    ifa.operand_B_type !== TYPE_B_RD2 || ifa.wb_sel !== WB_FROM_RESULT) begin
         errors++; $display("FAIL reset_ctrl got alu %h a %h b %h wb %h", ifa.alu_operation,
                            ifa.operand_A_type, ifa.operand_B_type, ifa.wb_sel); end
      checks++; if (ifa.illegal_count !== 16'h0 || ifa.illegal_flag !== 1'b0) begin errors++;
         $display("FAIL reset_illegal got cnt %h flag %h want 0", ifa.illegal_count,
                  ifa.illegal_flag); end
   endtask

   task automatic test_addi();
      drive(1'b1, 32'h00500093, 32'h100); tick(); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.rd !== 5'd1 || ifa.imm !== 32'd5) begin
         errors++; $display("FAIL addi_basic got v %h rd %h imm %h want 1 1 5", ifa.out_valid,
                            ifa.rd, ifa.imm); end
      checks++; if (ifa.operand_B_type !== TYPE_B_IMM_I || ifa.alu_operation !== ALU_ADD ||
                    ifa.reg_file_write_enable !== 1'b1) begin errors++;
         $display("FAIL addi_ctrl got b %h alu %h we %h", ifa.operand_B_type, ifa.alu_operation,
                  ifa.reg_file_write_enable); end
      checks++; if (ifa.out_pc !== 32'h100) begin errors++;
         $display("FAIL addi_pc got %h want 100", ifa.out_pc); end
      tick();
      checks++; if (ifa.out_valid !== 1'b0) begin errors++;
         $display("FAIL addi_drain got %h want 0", ifa.out_valid); end
   endtask

   task automatic test_beq();
      drive(1'b1, 32'hFE208EE3, 32'h104); tick(); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.imm !== 32'hFFFFFFFC || ifa.branch_flag !== 1'b1) begin errors++;
         $display("FAIL beq_imm got imm %h br %h want fffffffc 1", ifa.imm, ifa.branch_flag); end
      checks++; if (ifa.alu_operation !== ALU_EQ || ifa.rs1 !== 5'd1 || ifa.rs2 !== 5'd2 ||
                    ifa.reg_file_write_enable !== 1'b0) begin errors++;
         $display("FAIL beq_ctrl got alu %h rs1 %h rs2 %h we %h", ifa.alu_operation, ifa.rs1,
                  ifa.rs2, ifa.reg_file_write_enable); end
   endtask

   task automatic test_mul();
      drive(1'b1, 32'h022081B3, 32'h108); tick(); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.alu_operation !== ALU_MUL || ifa.illegal_flag !== 1'b0 ||
                    ifa.reg_file_write_enable !== 1'b1) begin errors++;
         $display("FAIL mul_en got alu %h ill %h we %h", ifa.alu_operation, ifa.illegal_flag,
                  ifa.reg_file_write_enable); end
      checks++; if (ifb.illegal_flag !== 1'b1 || ifb.reg_file_write_enable !== 1'b0 ||
                    ifb.memory_require !== 1'b0 || ifb.alu_operation !== ALU_ADD) begin
         errors++; $display("FAIL mul_dis got ill %h we %h mem %h alu %h", ifb.illegal_flag,
                            ifb.reg_file_write_enable, ifb.memory_require, ifb.alu_operation); end
      checks++; if (ifb.illegal_count !== 2'd1 || ifa.illegal_count !== 16'd0) begin errors++;
         $display("FAIL mul_count got b %h a %h want 1 0", ifb.illegal_count,
                  ifa.illegal_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] instrs [3] = '{32'h00500093, 32'hFE208EE3, 32'h123452B7};
      set_ready(1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, instrs[i], 32'h400 + 32'(4 * i)); tick();
         checks++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h400 + 32'(4 * i)) begin
            errors++; $display("FAIL b2b_%0d got v %h pc %h", i, ifa.out_valid, ifa.out_pc); end
      end
      drive(1'b0, 32'h0, 32'h0); tick();
   endtask

   task automatic test_backpressure();
      set_ready(1'b0);
      drive(1'b1, 32'h00500093, 32'h200); tick();
      drive(1'b1, 32'h123452B7, 32'h204); #1;
      checks++; if (ifa.in_ready !== 1'b0) begin errors++;
         $display("FAIL bp_in_ready got %h want 0", ifa.in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h200 || ifa.imm !== 32'd5 ||
                       ifa.rd !== 5'd1 || ifa.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_hold_%0d got v %h pc %h imm %h rd %h rdy %h", i, ifa.out_valid,
                     ifa.out_pc, ifa.imm, ifa.rd, ifa.in_ready); end
      end
      set_ready(1'b1); #1;
      checks++; if (ifa.in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release got %h want 1", ifa.in_ready); end
      tick(); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h204 || ifa.rd !== 5'd5 ||
                    ifa.imm !== 32'h12345000 || ifa.operand_A_type !== TYPE_A_ZERO ||
                    ifa.operand_B_type !== TYPE_B_IMM_U) begin errors++;
         $display("FAIL bp_next got v %h pc %h rd %h imm %h a %h b %h", ifa.out_valid, ifa.out_pc,
                  ifa.rd, ifa.imm, ifa.operand_A_type, ifa.operand_B_type); end
      tick();
   endtask

   task automatic test_flush();
      set_ready(1'b0);
      drive(1'b1, 32'h00500093, 32'h300); tick();
      checks++; if (ifa.out_valid !== 1'b1) begin errors++;
         $display("FAIL flush_pre got %h want 1", ifa.out_valid); end
      set_ready(1'b1); set_flush(1'b1); drive(1'b1, 32'h00000000, 32'h304); tick();
      set_flush(1'b0); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin errors++;
         $display("FAIL flush_kill got a %h b %h want 0 0", ifa.out_valid, ifb.out_valid); end
      checks++; if (ifb.illegal_count !== 2'd1) begin errors++;
         $display("FAIL flush_count got %h want 1", ifb.illegal_count); end
      tick();
      checks++; if (ifa.out_valid !== 1'b0) begin errors++;
         $display("FAIL flush_after got %h want 0", ifa.out_valid); end
   endtask

   task automatic test_system();
      set_ready(1'b1);
      drive(1'b1, 32'h00000073, 32'h600); tick();
      checks++; if (ifa.stop_signal !== 1'b1 || ifa.reg_file_write_enable !== 1'b0 ||
                    ifa.illegal_flag !== 1'b0) begin errors++;
         $display("FAIL ecall got stop %h we %h ill %h", ifa.stop_signal,
                  ifa.reg_file_write_enable, ifa.illegal_flag); end
      drive(1'b1, 32'h300092F3, 32'h604); tick();
      checks++; if (ifa.reg_file_write_enable !== 1'b1 || ifa.wb_sel !== WB_FROM_CSR ||
                    ifa.csr_op !== CSR_OP_RW || ifa.stop_signal !== 1'b0) begin errors++;
         $display("FAIL csrrw got we %h wb %h op %h stop %h", ifa.reg_file_write_enable,
                  ifa.wb_sel, ifa.csr_op, ifa.stop_signal); end
      checks++; if (ifb.illegal_flag !== 1'b1 || ifb.reg_file_write_enable !== 1'b0) begin
         errors++; $display("FAIL csrrw_dis got ill %h we %h", ifb.illegal_flag,
                            ifb.reg_file_write_enable); end
      drive(1'b1, 32'h30200073, 32'h608); tick();
      checks++; if (ifa.mret_flag !== 1'b1 || ifa.illegal_flag !== 1'b0) begin errors++;
         $display("FAIL mret got mret %h ill %h", ifa.mret_flag, ifa.illegal_flag); end
      drive(1'b1, 32'h0000000F, 32'h60C); tick(); drive(1'b0, 32'h0, 32'h0);
      checks++; if (ifa.illegal_flag !== 1'b0 || ifa.reg_file_write_enable !== 1'b0 ||
                    ifa.memory_require !== 1'b0 || ifa.mret_flag !== 1'b0) begin errors++;
         $display("FAIL fence got ill %h we %h mem %h mret %h", ifa.illegal_flag,
                  ifa.reg_file_write_enable, ifa.memory_require, ifa.mret_flag); end
      tick();
   endtask

   task automatic test_counter();
      logic [1:0] exp_cnt;
      reset = 1'b1; tick(); reset = 1'b0;
      set_ready(1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h00000000, 32'h500 + 32'(4 * i)); tick();
         exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++; if (ifb.illegal_count !== exp_cnt) begin errors++;
            $display("FAIL count_%0d got %0d want %0d", i, ifb.illegal_count, exp_cnt); end
      end
      checks++; if (ifa.illegal_flag !== 1'b1 || ifa.reg_file_write_enable !== 1'b0 ||
                    ifa.illegal_count !== 16'd5) begin errors++;
         $display("FAIL zero_word got ill %h we %h cnt %0d", ifa.illegal_flag,
                  ifa.reg_file_write_enable, ifa.illegal_count); end
      drive(1'b1, 32'h00500093, 32'h700); set_ready(1'b0);
      reset = 1'b1; tick(); reset = 1'b0; drive(1'b0, 32'h0, 32'h0); #1;
      checks++; if (ifb.out_valid !== 1'b0 || ifb.illegal_count !== 2'd0 ||
                    ifb.in_ready !== 1'b1) begin errors++;
         $display("FAIL post_reset got v %h cnt %h rdy %h", ifb.out_valid, ifb.illegal_count,
                  ifb.in_ready); end
      checks++; if (ifb.illegal_flag !== 1'b0 || ifb.imm !== 32'h0 || ifb.out_pc !== 32'h0 ||
                    ifb.rs1 !== 5'h0 || ifb.rs2 !== 5'h0 || ifb.rd !== 5'h0 ||
                    ifb.alu_operation !== ALU_ADD || ifb.memory_size !== DATA_SIZE_BYTE ||
                    ifb.wb_sel !== WB_FROM_RESULT || ifb.csr_op !== 3'h0) begin errors++;
         $display("FAIL post_reset_out got ill %h imm %h pc %h rd %h alu %h", ifb.illegal_flag,
                  ifb.imm, ifb.out_pc, ifb.rd, ifb.alu_operation); end
      checks++; if (ifa.illegal_count !== 16'd0) begin errors++;
         $display("FAIL post_reset_cnt_a got %0d want 0", ifa.illegal_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_addi();
      test_beq();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_system();
      test_counter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
